memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  stage clock; reset  in  1  synchronous, active-high; one clock, no other clock domains.
REQ-002 SHALL have: validIn  in  1  execute-stage result valid; ALU_Result  in  32  address or pass-through result; dataInMemory  in  32  store data.
REQ-003 SHALL have: SIG_MemRead  in  1; SIG_MemWrite  in  1; SIG_MemSize  in  2  (00 byte, 01 half, 10 word, 11 reserved=word); SIG_MemSigned  in  1  sign-extend loads.
REQ-004 SHALL have: SIG_RegWrite  in  1; destReg  in  5  writeback register index.
REQ-005 SHALL have memory-side ports: memReq  out  1; memWriteEn  out  1; memAddr  out  32  word-aligned; memWData  out  32; memByteEn  out  4; memAck  in  1; memRData  in  32.
REQ-006 SHALL have: memStall  out  1  upstream hold; validOut  out  1; writeBackData  out  32; destRegOut  out  5; regWriteOut  out  1; misalignFault  out  1  one-cycle pulse; timeoutFault  out  1  one-cycle pulse.

Function
REQ-007 SHALL accept an operation when validIn=1 and memStall=0; upstream holds all inputs stable while memStall=1.
REQ-008 Non-memory op (read=write=0): SHALL register ALU_Result to writeBackData with validOut=1 one cycle after acceptance (latency 1).
REQ-009 SHALL use FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on accepted aligned memory op; ACCESS->DONE on memAck=1; ACCESS->IDLE on timeout; DONE->IDLE unconditionally.
REQ-010 In ACCESS: memReq=1, memAddr={addr[31:2],2'b00}, memWriteEn=SIG_MemWrite, memByteEn and memWData held constant until memAck.
REQ-011 memStall SHALL equal (state==ACCESS && !memAck) || (state==IDLE && accepted memory op); no new op accepted in ACCESS or DONE.
REQ-012 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; little-endian lanes.
REQ-013 Store data: byte replicated {4{d[7:0]}}; half {2{d[15:0]}}; word d.
REQ-014 Load: memRData SHALL be captured on memAck, lane selected by addr[1:0], zero- or sign-extended per SIG_MemSigned; presented in DONE with validOut=1.
REQ-015 Store completion SHALL produce validOut=1 in DONE with regWriteOut=0.
REQ-016 SIG_MemRead and SIG_MemWrite both 1 SHALL be treated as write.
REQ-017 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): SHALL not assert memReq; SHALL pulse misalignFault and validOut next cycle with regWriteOut=0.
REQ-018 Timeout: 8-bit counter cleared on entering ACCESS; at 255 cycles without memAck SHALL drop memReq, pulse timeoutFault and validOut with regWriteOut=0, return to IDLE.
REQ-019 memAck outside ACCESS SHALL be ignored.
REQ-020 validOut SHALL be a single-cycle pulse per accepted operation; destRegOut/regWriteOut travel with it.

Reset
REQ-021 On reset=1 at a clk edge: state=IDLE, counter=0, all outputs 0 (memReq, memWriteEn, memByteEn, memAddr, memWData, memStall, validOut, writeBackData, destRegOut, regWriteOut, faults).
REQ-022 Reset mid-ACCESS SHALL abort the transaction; memReq low the cycle after; no validOut for the aborted op.

Structure
REQ-023 Shared package SHALL hold the mem-size encoding enum, FSM state enum, and TIMEOUT_CYCLES=255.
REQ-024 Load-extract/store-align logic SHALL be one combinational sub-module, mem_lane_align; FSM, counter, and output registers stay in the top.

Verification
REQ-025 ALU op, ALU_Result=32'h0000_1234, RegWrite=1, dest=5 -> next cycle validOut=1, writeBackData=32'h0000_1234, destRegOut=5, memReq never asserted.
REQ-026 Signed byte load addr=32'h0000_0103, memRData=32'h80FF_0000, ack after 3 wait cycles -> memAddr=32'h0000_0100, memByteEn=4'b1000, memStall high 4 cycles, writeBackData=32'hFFFF_FF80.
REQ-027 Half store addr=32'h0000_0202, data=32'hAAAA_BEEF, immediate ack -> memByteEn=4'b1100, memWData=32'hBEEF_BEEF, validOut=1, regWriteOut=0.
REQ-028 Word load addr=32'h0000_0006 -> misalignFault pulse, memReq stays 0, validOut=1 with regWriteOut=0.
REQ-029 Word load, memAck never asserted -> timeoutFault pulse after 255 ACCESS cycles, memReq drops, FSM returns to IDLE and accepts next op.
REQ-030 Reset asserted during the 2nd wait cycle of a load -> all outputs 0 next cycle; late memAck ignored; no validOut.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory access stage: access-size encoding,
// FSM states, timeout limit and the latched operation record.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // reserved, behaves as word
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam int TIMEOUT_CYCLES = 255;
  localparam int CNT_W          = 8;

  // Operation fields latched on acceptance so the stage does not rely on
  // upstream holding its inputs for the whole bus transaction.
  typedef struct packed {
    logic [1:0]  lane;
    mem_size_e   size;
    logic        sgn;
    logic        wr;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] alu;
  } mem_op_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Memory-side bus of the stage: request/address/data out, ack/read data in.
interface memory_access_stage_if;
  logic        memReq;
  logic        memWriteEn;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRData;

  modport master (
    output memReq, memWriteEn, memAddr, memWData, memByteEn,
    input  memAck, memRData
  );

  modport slave (
    input  memReq, memWriteEn, memAddr, memWData, memByteEn,
    output memAck, memRData
  );
endinterface

// File: rtl/memory_access_stage_lane_align.sv
// Combinational lane logic: store byte-enables and data replication,
// load lane extraction with zero/sign extension, and alignment check.
module mem_lane_align
  import memory_access_stage_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        sgn_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed lane and build enables/data for the access size
  always_comb begin
    ld_byte    = 8'(ld_raw_i >> {lane_i, 3'b000});
    ld_half    = lane_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    byte_en_o  = 4'b1111;
    st_data_o  = st_data_i;
    ld_data_o  = ld_raw_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        byte_en_o = 4'b0001 << lane_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sgn_i & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        byte_en_o  = 4'b0011 << {lane_i[1], 1'b0};
        st_data_o  = {2{st_data_i[15:0]}};
        ld_data_o  = {{16{sgn_i & ld_half[15]}}, ld_half};
        misalign_o = lane_i[0];
      end
      default: misalign_o = |lane_i;   // word and reserved
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: passes ALU results through with one cycle
// latency, or runs a single-outstanding load/store on the memory bus with
// misalignment and timeout detection.
module memory_access_stage
  import memory_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        validIn,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] dataInMemory,
  input  logic        SIG_MemRead,
  input  logic        SIG_MemWrite,
  input  logic [1:0]  SIG_MemSize,
  input  logic        SIG_MemSigned,
  input  logic        SIG_RegWrite,
  input  logic [4:0]  destReg,
  memory_access_stage_if.master mem,
  output logic        memStall,
  output logic        validOut,
  output logic [31:0] writeBackData,
  output logic [4:0]  destRegOut,
  output logic        regWriteOut,
  output logic        misalignFault,
  output logic        timeoutFault
);

  state_e           state_q, state_d;
  mem_op_t          op_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_mem, accept, go_access, timeout_hit, in_idle;
  logic        memReq_o, memStall_o;

  logic [31:0] memAddr_q, memWData_q;
  logic [3:0]  memByteEn_q;
  logic        memWriteEn_q;

  logic        vld_q, vld_d, rw_q, rw_d, mis_q, mis_d, to_q, to_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  dest_q, dest_d;

  mem_size_e   al_size;
  logic        al_sgn, al_mis;
  logic [1:0]  al_lane;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  assign in_idle     = (state_q == ST_IDLE);
  assign is_mem      = SIG_MemRead | SIG_MemWrite;
  assign accept      = validIn & in_idle;
  assign go_access   = accept & is_mem & ~al_mis;
  assign timeout_hit = (state_q == ST_ACCESS) & ~mem.memAck
                     & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // The aligner sees live inputs while idle (store alignment, misalign
  // check) and the latched op while accessing (load extraction).
  assign al_size = in_idle ? mem_size_e'(SIG_MemSize) : op_q.size;
  assign al_sgn  = in_idle ? SIG_MemSigned : op_q.sgn;
  assign al_lane = in_idle ? ALU_Result[1:0] : op_q.lane;

  mem_lane_align u_align (
    .size_i     (al_size),
    .sgn_i      (al_sgn),
    .lane_i     (al_lane),
    .st_data_i  (dataInMemory),
    .ld_raw_i   (mem.memRData),
    .byte_en_o  (al_be),
    .st_data_o  (al_wdata),
    .ld_data_o  (al_ldata),
    .misalign_o (al_mis)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go_access) state_d = ST_ACCESS;
      ST_ACCESS: if (mem.memAck) state_d = ST_DONE;
                 else if (timeout_hit) state_d = ST_IDLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bus request while accessing, upstream hold
  always_comb begin
    memReq_o   = (state_q == ST_ACCESS);
    memStall_o = ((state_q == ST_ACCESS) & ~mem.memAck) | go_access;
  end

  // Latch the op and drive the bus registers; cleared when the access ends
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      cnt_q        <= '0;
      memAddr_q    <= '0;
      memWData_q   <= '0;
      memByteEn_q  <= '0;
      memWriteEn_q <= 1'b0;
    end else if (go_access) begin
      op_q         <= '{lane: ALU_Result[1:0], size: mem_size_e'(SIG_MemSize),
                        sgn: SIG_MemSigned, wr: SIG_MemWrite, rw: SIG_RegWrite,
                        dest: destReg, alu: ALU_Result};
      cnt_q        <= '0;
      memAddr_q    <= {ALU_Result[31:2], 2'b00};
      memWData_q   <= al_wdata;
      memByteEn_q  <= al_be;
      memWriteEn_q <= SIG_MemWrite;
    end else if (state_q == ST_ACCESS) begin
      if (mem.memAck || timeout_hit) begin
        memAddr_q    <= '0;
        memWData_q   <= '0;
        memByteEn_q  <= '0;
        memWriteEn_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Writeback result for next cycle: pass-through, misalign, completion, timeout
  always_comb begin
    vld_d  = 1'b0;
    rw_d   = 1'b0;
    mis_d  = 1'b0;
    to_d   = 1'b0;
    wb_d   = wb_q;
    dest_d = dest_q;
    if (accept && !go_access) begin
      vld_d  = 1'b1;
      wb_d   = ALU_Result;
      dest_d = destReg;
      rw_d   = SIG_RegWrite & ~is_mem;
      mis_d  = is_mem;
    end else if ((state_q == ST_ACCESS) && mem.memAck) begin
      vld_d  = 1'b1;
      dest_d = op_q.dest;
      wb_d   = op_q.wr ? op_q.alu : al_ldata;
      rw_d   = op_q.rw & ~op_q.wr;
    end else if (timeout_hit) begin
      vld_d  = 1'b1;
      to_d   = 1'b1;
      dest_d = op_q.dest;
    end
  end

  // Writeback output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      rw_q   <= 1'b0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
      wb_q   <= '0;
      dest_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rw_q   <= rw_d;
      mis_q  <= mis_d;
      to_q   <= to_d;
      wb_q   <= wb_d;
      dest_q <= dest_d;
    end
  end

  assign mem.memReq     = memReq_o;
  assign mem.memWriteEn = memWriteEn_q;
  assign mem.memAddr    = memAddr_q;
  assign mem.memWData   = memWData_q;
  assign mem.memByteEn  = memByteEn_q;
  assign memStall       = memStall_o;
  assign validOut       = vld_q;
  assign writeBackData  = wb_q;
  assign destRegOut     = dest_q;
  assign regWriteOut    = rw_q;
  assign misalignFault  = mis_q;
  assign timeoutFault   = to_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: pass-through, loads, stores,
// misalignment, timeout and mid-access reset with hand-computed results.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic [31:0] ALU_Result, dataInMemory;
  logic        SIG_MemRead, SIG_MemWrite, SIG_MemSigned, SIG_RegWrite;
  logic [1:0]  SIG_MemSize;
  logic [4:0]  destReg;
  logic        memStall, validOut, regWriteOut, misalignFault, timeoutFault;
  logic [31:0] writeBackData;
  logic [4:0]  destRegOut;

  int n_chk = 0;
  int n_fail = 0;

  memory_access_stage_if mem_bus ();

  memory_access_stage dut (
    .clk(clk), .reset(reset), .validIn(validIn), .ALU_Result(ALU_Result),
    .dataInMemory(dataInMemory), .SIG_MemRead(SIG_MemRead),
    .SIG_MemWrite(SIG_MemWrite), .SIG_MemSize(SIG_MemSize),
    .SIG_MemSigned(SIG_MemSigned), .SIG_RegWrite(SIG_RegWrite),
    .destReg(destReg), .mem(mem_bus), .memStall(memStall),
    .validOut(validOut), .writeBackData(writeBackData),
    .destRegOut(destRegOut), .regWriteOut(regWriteOut),
    .misalignFault(misalignFault), .timeoutFault(timeoutFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [1:0] sz, input logic sg, input logic rd,
                        input logic wr, input logic rw, input logic [4:0] dst);
    validIn = 1'b1; ALU_Result = addr; dataInMemory = wdat; SIG_MemSize = sz;
    SIG_MemSigned = sg; SIG_MemRead = rd; SIG_MemWrite = wr;
    SIG_RegWrite = rw; destReg = dst;
  endtask

  // Aligned load/store: ack after 'waits' idle ACCESS cycles; returns the
  // stall count, bus fields seen in the first ACCESS cycle and DONE outputs.
  task automatic mem_txn(input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input logic [1:0] sz,
                         input logic sg, input logic rd, input logic wr,
                         input logic rw, input logic [4:0] dst, input int waits,
                         output int stalls, output logic [31:0] o_addr,
                         output logic [31:0] o_wdata, output logic [3:0] o_be,
                         output logic o_we, output logic o_vld,
                         output logic [31:0] o_wb, output logic o_rw,
                         output logic [4:0] o_dst);
    stalls = 0;
    set_op(addr, wdat, sz, sg, rd, wr, rw, dst);
    #3;
    if (memStall) stalls++;
    for (int i = 0; i <= waits; i++) begin
      cyc();
      if (i == waits) begin
        mem_bus.memAck = 1'b1; mem_bus.memRData = rdat;
      end
      #3;
      if (i == 0) begin
        o_addr = mem_bus.memAddr; o_wdata = mem_bus.memWData;
        o_be = mem_bus.memByteEn; o_we = mem_bus.memWriteEn;
      end
      if (memStall) stalls++;
    end
    cyc();
    validIn = 1'b0; mem_bus.memAck = 1'b0; mem_bus.memRData = '0;
    #3;
    o_vld = validOut; o_wb = writeBackData; o_rw = regWriteOut; o_dst = destRegOut;
  endtask

  int          st, n;
  logic [31:0] a, wd, wb;
  logic [3:0]  be;
  logic        we, vo, rwo;
  logic [4:0]  dd;

  initial begin
    reset = 1'b1; validIn = 1'b0; ALU_Result = '0; dataInMemory = '0;
    SIG_MemRead = 1'b0; SIG_MemWrite = 1'b0; SIG_MemSize = 2'b00;
    SIG_MemSigned = 1'b0; SIG_RegWrite = 1'b0; destReg = '0;
    mem_bus.memAck = 1'b0; mem_bus.memRData = '0;
    cyc(); cyc(); #3;
    chk("rst_req",   32'(mem_bus.memReq), 32'd0);
    chk("rst_stall", 32'(memStall), 32'd0);
    chk("rst_vld",   32'(validOut), 32'd0);
    chk("rst_bus",   {mem_bus.memAddr[27:0], mem_bus.memByteEn}, 32'd0);
    chk("rst_wb",    writeBackData, 32'd0);
    cyc(); reset = 1'b0;

    // ALU pass-through
    cyc(); set_op(32'h0000_1234, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    #3; chk("alu_stall", 32'(memStall), 32'd0);
    cyc(); validIn = 1'b0; #3;
    chk("alu_vld",  32'(validOut), 32'd1);
    chk("alu_wb",   writeBackData, 32'h0000_1234);
    chk("alu_dst",  32'(destRegOut), 32'd5);
    chk("alu_rw",   32'(regWriteOut), 32'd1);
    chk("alu_req",  32'(mem_bus.memReq), 32'd0);
    cyc(); #3; chk("alu_pulse", 32'(validOut), 32'd0);

    // Signed byte load, 3 wait cycles
    cyc();
    mem_txn(32'h0000_0103, 32'h0, 32'h80FF_0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1,
            5'd7, 3, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("lb_addr", a, 32'h0000_0100);
    chk("lb_be",   32'(be), 32'h8);
    chk("lb_we",   32'(we), 32'd0);
    chk("lb_stall", 32'(st), 32'd4);
    chk("lb_vld",  32'(vo), 32'd1);
    chk("lb_wb",   wb, 32'hFFFF_FF80);
    chk("lb_rw",   32'(rwo), 32'd1);
    chk("lb_dst",  32'(dd), 32'd7);
    cyc(); #3; chk("lb_pulse", 32'(validOut), 32'd0);

    // Half store, immediate ack
    mem_txn(32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1,
            5'd2, 0, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("sh_be",    32'(be), 32'hC);
    chk("sh_wd",    wd, 32'hBEEF_BEEF);
    chk("sh_we",    32'(we), 32'd1);
    chk("sh_addr",  a, 32'h0000_0200);
    chk("sh_stall", 32'(st), 32'd1);
    chk("sh_vld",   32'(vo), 32'd1);
    chk("sh_rw",    32'(rwo), 32'd0);

    // Read+write together acts as a byte store
    cyc();
    mem_txn(32'h0000_0301, 32'h1234_5678, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
            5'd4, 1, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("rw_be", 32'(be), 32'h2);
    chk("rw_wd", wd, 32'h7878_7878);
    chk("rw_we", 32'(we), 32'd1);
    chk("rw_rw", 32'(rwo), 32'd0);

    // Unsigned half load from upper lane, signed half from lower, word load
    cyc();
    mem_txn(32'h0000_0402, 32'h0, 32'h8001_7FFF, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1,
            5'd8, 0, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("lhu_be", 32'(be), 32'hC);
    chk("lhu_wb", wb, 32'h0000_8001);
    cyc();
    mem_txn(32'h0000_0400, 32'h0, 32'h1234_F00D, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1,
            5'd8, 2, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("lh_be", 32'(be), 32'h3);
    chk("lh_wb", wb, 32'hFFFF_F00D);
    cyc();
    mem_txn(32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1,
            5'd9, 1, st, a, wd, be, we, vo, wb, rwo, dd);
    chk("lw_be", 32'(be), 32'hF);
    chk("lw_wb", wb, 32'hDEAD_BEEF);

    // Misaligned word load
    cyc(); set_op(32'h0000_0006, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9);
    #3; chk("mis_stall", 32'(memStall), 32'd0);
    cyc(); validIn = 1'b0; #3;
    chk("mis_fault", 32'(misalignFault), 32'd1);
    chk("mis_vld",   32'(validOut), 32'd1);
    chk("mis_rw",    32'(regWriteOut), 32'd0);
    chk("mis_req",   32'(mem_bus.memReq), 32'd0);
    cyc(); #3; chk("mis_pulse", 32'(misalignFault), 32'd0);

    // Stray ack while idle is ignored
    mem_bus.memAck = 1'b1; mem_bus.memRData = 32'h5555_5555;
    cyc(); mem_bus.memAck = 1'b0; #3;
    chk("ack_idle_vld", 32'(validOut), 32'd0);
    chk("ack_idle_req", 32'(mem_bus.memReq), 32'd0);

    // Timeout: word load never acked
    cyc(); set_op(32'h0000_0040, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
    cyc(); validIn = 1'b0; #3;
    n = 0;
    while (mem_bus.memReq && n < 400) begin
      n++; cyc(); #3;
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_fault",  32'(timeoutFault), 32'd1);
    chk("to_vld",    32'(validOut), 32'd1);
    chk("to_rw",     32'(regWriteOut), 32'd0);
    set_op(32'h0000_0077, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    cyc(); validIn = 1'b0; #3;
    chk("to_pulse",  32'(timeoutFault), 32'd0);
    chk("to_next",   writeBackData, 32'h0000_0077);
    chk("to_nextv",  32'(validOut), 32'd1);

    // Reset during the second wait cycle of a load
    cyc(); set_op(32'h0000_0010, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);
    cyc(); validIn = 1'b0;      // wait 1
    cyc(); reset = 1'b1;        // wait 2
    cyc(); reset = 1'b0; mem_bus.memAck = 1'b1; mem_bus.memRData = 32'h1111_1111;
    #3;
    chk("rr_req",   32'(mem_bus.memReq), 32'd0);
    chk("rr_addr",  mem_bus.memAddr, 32'd0);
    chk("rr_be",    32'(mem_bus.memByteEn), 32'd0);
    chk("rr_stall", 32'(memStall), 32'd0);
    chk("rr_wb",    writeBackData, 32'd0);
    chk("rr_vld",   32'(validOut), 32'd0);
    cyc(); mem_bus.memAck = 1'b0; #3;
    chk("rr_late_vld", 32'(validOut), 32'd0);
    chk("rr_late_req", 32'(mem_bus.memReq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
